// File: rtl/multi_channel_pulse_detector.sv
// Per-channel edge and windowed high-pulse detector with N_CH independent inputs.
// Define MULTI_CHANNEL_PULSE_DETECTOR_SYNC_EN to add a 2-flop input synchroniser (+2 cycles latency).
module multi_channel_pulse_detector #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  a,
    input  logic [CNT_W-1:0] min_len,
    input  logic [CNT_W-1:0] max_len,
    output logic [N_CH-1:0]  posedge_det,
    output logic [N_CH-1:0]  negedge_det,
    output logic [N_CH-1:0]  detected
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  a_d;
    logic [N_CH-1:0]  a_r;
    logic [CNT_W-1:0] eff_min;

`ifdef MULTI_CHANNEL_PULSE_DETECTOR_SYNC_EN
    logic [N_CH-1:0] sync_q1;
    logic [N_CH-1:0] sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= a;
            sync_q2 <= sync_q1;
        end
    end

    assign a_d = sync_q2;
`else
    assign a_d = a;
`endif

    // A zero-length pulse cannot exist, so a zero minimum behaves as one.
    assign eff_min = (min_len == '0) ? CNT_W'(1) : min_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
        end else begin
            a_r <= a_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;

        // Saturating run-length: a full count means "at least CNT_MAX cycles".
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (a_d[i]) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end

        assign posedge_det[i] = a_d[i] & ~a_r[i];
        assign negedge_det[i] = a_r[i] & ~a_d[i];
        assign detected[i]    = negedge_det[i] & (cnt >= eff_min) & (cnt <= max_len);
    end

endmodule

// File: tb/tb_multi_channel_pulse_detector.sv
// Scoreboard bench for multi_channel_pulse_detector: directed scenarios plus random traffic
// checked against a run-length reference model.
module tb_multi_channel_pulse_detector;
    localparam int N_CH  = 4;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef MULTI_CHANNEL_PULSE_DETECTOR_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    typedef struct packed {
        logic [N_CH-1:0] p;
        logic [N_CH-1:0] n;
        logic [N_CH-1:0] d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  a = '0;
    logic [CNT_W-1:0] min_len = '0;
    logic [CNT_W-1:0] max_len = '0;
    logic [N_CH-1:0]  posedge_det;
    logic [N_CH-1:0]  negedge_det;
    logic [N_CH-1:0]  detected;

    multi_channel_pulse_detector #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .min_len     (min_len),
        .max_len     (max_len),
        .posedge_det (posedge_det),
        .negedge_det (negedge_det),
        .detected    (detected)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: level history and unbounded run length per channel.
    logic [N_CH-1:0] m_prev = '0;
    logic [N_CH-1:0] m_s1 = '0;
    logic [N_CH-1:0] m_s2 = '0;
    int              m_run [N_CH];

    initial for (int i = 0; i < N_CH; i++) m_run[i] = 0;

    task automatic apply(input logic [N_CH-1:0] av, input int mn, input int mx, input logic rv);
        exp_t            e;
        logic [N_CH-1:0] ad;
        int              eff;
        @(posedge clk);
        #1;
        a       = av;
        min_len = mn[CNT_W-1:0];
        max_len = mx[CNT_W-1:0];
        rst_n   = rv;
        if (!rv) begin
            m_prev = '0;
            m_s1   = '0;
            m_s2   = '0;
            for (int i = 0; i < N_CH; i++) m_run[i] = 0;
        end
        ad  = SYNC ? m_s2 : av;
        eff = (mn == 0) ? 1 : mn;
        for (int i = 0; i < N_CH; i++) begin
            e.p[i] = ad[i] & ~m_prev[i];
            e.n[i] = m_prev[i] & ~ad[i];
            e.d[i] = e.n[i] && (m_run[i] >= eff) &&
                     ((m_run[i] <= mx) || (m_run[i] >= MAXC && mx == MAXC));
        end
        exp_q.push_back(e);
        if (rv) begin
            for (int i = 0; i < N_CH; i++) m_run[i] = ad[i] ? m_run[i] + 1 : 0;
            m_prev = ad;
            m_s2   = m_s1;
            m_s1   = av;
        end
    endtask

    task automatic idle(input int n, input int mn, input int mx);
        for (int k = 0; k < n; k++) apply('0, mn, mx, 1'b1);
    endtask

    task automatic pulse0(input int len, input int gap, input int mn, input int mx);
        for (int k = 0; k < len; k++) apply(4'b0001, mn, mx, 1'b1);
        idle(gap, mn, mx);
    endtask

    // Monitor: outputs are valid every cycle, compare one expected entry per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (posedge_det !== e.p || negedge_det !== e.n || detected !== e.d) begin
                miscompares++;
                $display("FAIL vec%0d outputs: got pos=%b neg=%b det=%b, want pos=%b neg=%b det=%b",
                         vectors, posedge_det, negedge_det, detected, e.p, e.n, e.d);
            end
        end
    end

    initial begin
        logic [N_CH-1:0] lv;
        int              rem [N_CH];
        int              mn;
        int              mx;
        int              waited;

        // Reset state, including a combinational posedge during reset.
        apply(4'b0000, 1, 1, 1'b0);
        apply(4'b0101, 1, 1, 1'b0);
        apply(4'b0000, 1, 1, 1'b0);

        // 010 equivalence and 0110 rejection.
        apply(4'b0000, 1, 1, 1'b1);
        pulse0(1, 3, 1, 1);
        pulse0(2, 3, 1, 1);

        // Window [2,4] with lengths 1,2,4,5.
        pulse0(1, 3, 2, 4);
        pulse0(2, 3, 2, 4);
        pulse0(4, 3, 2, 4);
        pulse0(5, 3, 2, 4);

        // Saturation.
        pulse0(20, 3, 1, 15);
        pulse0(20, 3, 1, 14);
        pulse0(15, 3, 15, 15);
        pulse0(1, 3, 0, 15);

        // Simultaneous falls, lengths 1,2,3,9; then an empty window.
        for (int pass = 0; pass < 2; pass++) begin
            mn = (pass == 0) ? 2 : 5;
            for (int t = 0; t < 9; t++) begin
                lv = '0;
                if (t >= 8) lv[0] = 1'b1;
                if (t >= 7) lv[1] = 1'b1;
                if (t >= 6) lv[2] = 1'b1;
                lv[3] = 1'b1;
                apply(lv, mn, 3, 1'b1);
            end
            idle(3, mn, 3);
        end

        // Window moved mid-pulse: value at the falling edge decides.
        for (int k = 0; k < 3; k++) apply(4'b0001, 5, 6, 1'b1);
        apply(4'b0001, 1, 4, 1'b1);
        idle(2, 1, 4);

        // Reset mid-pulse.
        for (int k = 0; k < 3; k++) apply(4'b0001, 1, 1, 1'b1);
        apply(4'b0001, 1, 1, 1'b0);
        apply(4'b0001, 1, 1, 1'b1);
        idle(4, 1, 1);

        // Random traffic.
        for (int i = 0; i < N_CH; i++) rem[i] = 0;
        lv = '0;
        mn = 1;
        mx = 4;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                mn = $urandom_range(0, MAXC);
                mx = $urandom_range(0, MAXC);
            end
            for (int i = 0; i < N_CH; i++) begin
                if (rem[i] == 0) begin
                    lv[i]  = ~lv[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 22) : $urandom_range(1, 5);
                end
                rem[i]--;
            end
            apply(lv, mn, mx, ($urandom_range(0, 299) != 0));
        end
        idle(4, mn, mx);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
